// File: rtl/imem_load_ctrl_pkg.sv
// Shared types for the instruction-memory load controller.
// State encoding and the default fill instruction for bad fetches.
package imem_load_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/imem_byte_ram.sv
// Byte-wide program store: one byte write port and a
// registered big-endian 4-byte read starting at a base address.
module imem_byte_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data
);

  logic [7:0]    r_mem [DEPTH];
  logic [31:0]   r_rd_data;
  logic [AW-1:0] w_a1;
  logic [AW-1:0] w_a2;
  logic [AW-1:0] w_a3;

  assign w_a1 = i_rd_addr + AW'(1);
  assign w_a2 = i_rd_addr + AW'(2);
  assign w_a3 = i_rd_addr + AW'(3);

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= {r_mem[i_rd_addr], r_mem[w_a1],
                    r_mem[w_a2], r_mem[w_a3]};
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_load_ctrl.sv
// Loader/fetch sequencer around the byte program store.
// Loads stall the core; fetches are serviced only in RUN.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          AW        = 10,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_last,
  output logic        byte_ready,
  output logic        load_done,
  output logic [AW:0] load_count,
  output logic        cpu_stall,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_err
);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW:0]   r_load_count;
  logic [AW:0]   w_count_nxt;
  logic          r_load_done;
  logic          w_done_nxt;
  logic          w_we;
  logic          w_fetch_go;
  logic          w_fetch_bad;
  logic          r_fetch_valid;
  logic          r_fetch_err;
  logic [31:0]   w_rd_data;

  assign byte_ready = (r_state == ST_LOAD);
  assign cpu_stall  = (r_state != ST_RUN);

  // A load request in the same cycle wins over the fetch.
  assign w_fetch_go  = (r_state == ST_RUN) && fetch_req && !load_start;
  assign w_fetch_bad = (fetch_addr[1:0] != 2'b00) ||
                       (fetch_addr > 32'(DEPTH - 4));

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_load_count;
    w_done_nxt   = 1'b0;
    w_we         = 1'b0;
    if (load_start) begin
      w_state_nxt  = ST_LOAD;
      w_wr_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else if (byte_ready && byte_valid) begin
      w_we         = 1'b1;
      w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      w_count_nxt  = r_load_count + (AW+1)'(1);
      if (byte_last || (r_wr_ptr == AW'(DEPTH - 1))) begin
        w_state_nxt = ST_RUN;
        w_done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_wr_ptr      <= '0;
      r_load_count  <= '0;
      r_load_done   <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_load_count  <= w_count_nxt;
      r_load_done   <= w_done_nxt;
      r_fetch_valid <= w_fetch_go;
      if (w_fetch_go) r_fetch_err <= w_fetch_bad;
    end
  end

  imem_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_we),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (byte_data),
    .i_rd_en   (w_fetch_go),
    .i_rd_addr (fetch_addr[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  assign load_done   = r_load_done;
  assign load_count  = r_load_count;
  assign fetch_valid = r_fetch_valid;
  assign fetch_err   = r_fetch_err;
  assign fetch_instr = r_fetch_err ? NOP_INSTR : w_rd_data;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: load, fetch, error,
// overflow, load/fetch collision and mid-load reset.
module tb_imem_load_ctrl;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic        load_done;
  logic [AW:0] load_count;
  logic        cpu_stall;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_load_ctrl #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_last   (byte_last),
    .byte_ready  (byte_ready),
    .load_done   (load_done),
    .load_count  (load_count),
    .cpu_stall   (cpu_stall),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_err   (fetch_err)
  );

  task automatic do_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = l;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    @(negedge clk);
    fetch_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks += 7;
    if (cpu_stall !== 1'b1) begin
      errors++; $display("FAIL rst_stall got %b exp 1", cpu_stall);
    end
    if (byte_ready !== 1'b0) begin
      errors++; $display("FAIL rst_ready got %b exp 0", byte_ready);
    end
    if (load_done !== 1'b0) begin
      errors++; $display("FAIL rst_done got %b exp 0", load_done);
    end
    if (load_count !== '0) begin
      errors++; $display("FAIL rst_count got %0d exp 0", load_count);
    end
    if (fetch_valid !== 1'b0) begin
      errors++; $display("FAIL rst_fvalid got %b exp 0", fetch_valid);
    end
    if (fetch_instr !== 32'h0) begin
      errors++; $display("FAIL rst_instr got %h exp 0", fetch_instr);
    end
    if (fetch_err !== 1'b0) begin
      errors++; $display("FAIL rst_ferr got %b exp 0", fetch_err);
    end
  endtask

  task automatic test_basic();
    do_start();
    push(8'h00, 1'b0);
    push(8'h90, 1'b0);
    push(8'h05, 1'b0);
    push(8'h13, 1'b1);
    checks += 3;
    if (load_done !== 1'b1) begin
      errors++; $display("FAIL basic_done got %b exp 1", load_done);
    end
    if (load_count !== 11'd4) begin
      errors++; $display("FAIL basic_count got %0d exp 4", load_count);
    end
    if (cpu_stall !== 1'b0) begin
      errors++; $display("FAIL basic_stall got %b exp 0", cpu_stall);
    end
    fetch(32'h0);
    checks += 4;
    if (load_done !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse got %b exp 0", load_done);
    end
    if (fetch_valid !== 1'b1) begin
      errors++; $display("FAIL basic_fvalid got %b exp 1", fetch_valid);
    end
    if (fetch_instr !== 32'h0090_0513) begin
      errors++;
      $display("FAIL basic_instr got %h exp 00900513", fetch_instr);
    end
    if (fetch_err !== 1'b0) begin
      errors++; $display("FAIL basic_ferr got %b exp 0", fetch_err);
    end
    @(negedge clk);
    checks += 2;
    if (fetch_valid !== 1'b0) begin
      errors++; $display("FAIL basic_fvalid_drop got %b exp 0", fetch_valid);
    end
    if (fetch_instr !== 32'h0090_0513) begin
      errors++; $display("FAIL basic_hold got %h exp 00900513", fetch_instr);
    end
  endtask

  task automatic test_toggle();
    logic [7:0] v [8];
    v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_start();
    for (int i = 0; i < 8; i++) begin
      push(v[i], i == 7);
      if (i != 7) begin
        byte_data = 8'hEE;
        byte_last = 1'b1;
        @(negedge clk);
        byte_last = 1'b0;
      end
    end
    checks += 2;
    if (load_done !== 1'b1) begin
      errors++; $display("FAIL tog_done got %b exp 1", load_done);
    end
    if (load_count !== 11'd8) begin
      errors++; $display("FAIL tog_count got %0d exp 8", load_count);
    end
    fetch(32'h0);
    checks++;
    if (fetch_instr !== 32'h1122_3344) begin
      errors++; $display("FAIL tog_w0 got %h exp 11223344", fetch_instr);
    end
    fetch(32'h4);
    checks++;
    if (fetch_instr !== 32'h5566_7788) begin
      errors++; $display("FAIL tog_w1 got %h exp 55667788", fetch_instr);
    end
  endtask

  task automatic test_full();
    do_start();
    byte_valid = 1'b1;
    byte_last  = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      byte_data = 8'(i) ^ 8'h5A;
      checks++;
      if (byte_ready !== (i < DEPTH)) begin
        errors++;
        $display("FAIL full_ready[%0d] got %b exp %b", i, byte_ready,
                 i < DEPTH);
      end
      if (i == DEPTH) begin
        checks += 2;
        if (load_done !== 1'b1) begin
          errors++; $display("FAIL full_done got %b exp 1", load_done);
        end
        if (load_count !== 11'd1024) begin
          errors++;
          $display("FAIL full_count got %0d exp 1024", load_count);
        end
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
    fetch(32'(DEPTH - 4));
    checks += 3;
    if (fetch_valid !== 1'b1) begin
      errors++; $display("FAIL full_top_valid got %b exp 1", fetch_valid);
    end
    if (fetch_instr !== 32'hA6A7_A4A5) begin
      errors++; $display("FAIL full_top got %h exp a6a7a4a5", fetch_instr);
    end
    if (fetch_err !== 1'b0) begin
      errors++; $display("FAIL full_top_err got %b exp 0", fetch_err);
    end
    fetch(32'(DEPTH));
    checks += 2;
    if (fetch_instr !== NOP) begin
      errors++; $display("FAIL full_oor got %h exp %h", fetch_instr, NOP);
    end
    if (fetch_err !== 1'b1) begin
      errors++; $display("FAIL full_oor_err got %b exp 1", fetch_err);
    end
  endtask

  task automatic test_errors();
    logic [31:0] a [3];
    a = '{32'h0000_0002, 32'h8000_0000, 32'h0000_1000};
    for (int i = 0; i < 3; i++) begin
      fetch(a[i]);
      checks += 3;
      if (fetch_valid !== 1'b1) begin
        errors++; $display("FAIL err_valid[%h] got %b exp 1", a[i], fetch_valid);
      end
      if (fetch_instr !== NOP) begin
        errors++;
        $display("FAIL err_instr[%h] got %h exp %h", a[i], fetch_instr, NOP);
      end
      if (fetch_err !== 1'b1) begin
        errors++; $display("FAIL err_flag[%h] got %b exp 1", a[i], fetch_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    @(negedge clk);
    fetch_addr = 32'h4;
    checks += 3;
    if (fetch_valid !== 1'b1 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_v0 got v=%b e=%b exp v=1 e=0", fetch_valid, fetch_err);
    end
    if (fetch_instr !== 32'h5A5B_5859) begin
      errors++; $display("FAIL b2b_w0 got %h exp 5a5b5859", fetch_instr);
    end
    @(negedge clk);
    fetch_req = 1'b0;
    if (fetch_instr !== 32'h5E5F_5C5D || fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_w1 got %h v=%b exp 5e5f5c5d v=1", fetch_instr,
               fetch_valid);
    end
  endtask

  task automatic test_start_fetch();
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    @(negedge clk);
    load_start = 1'b0;
    fetch_req  = 1'b0;
    checks += 3;
    if (fetch_valid !== 1'b0) begin
      errors++; $display("FAIL coll_fvalid got %b exp 0", fetch_valid);
    end
    if (cpu_stall !== 1'b1) begin
      errors++; $display("FAIL coll_stall got %b exp 1", cpu_stall);
    end
    if (byte_ready !== 1'b1) begin
      errors++; $display("FAIL coll_ready got %b exp 1", byte_ready);
    end
    push(8'hC3, 1'b1);
    checks++;
    if (load_count !== 11'd1) begin
      errors++; $display("FAIL coll_count got %0d exp 1", load_count);
    end
    fetch(32'h0);
    checks++;
    if (fetch_instr !== 32'hC35B_5859) begin
      errors++; $display("FAIL coll_word got %h exp c35b5859", fetch_instr);
    end
  endtask

  task automatic test_rst_midload();
    logic [7:0] v [8];
    v = '{8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h01, 8'h13};
    do_start();
    push(8'hAA, 1'b0);
    push(8'hBB, 1'b0);
    push(8'hCC, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 3;
    if (load_count !== '0) begin
      errors++; $display("FAIL mrst_count got %0d exp 0", load_count);
    end
    if (cpu_stall !== 1'b1) begin
      errors++; $display("FAIL mrst_stall got %b exp 1", cpu_stall);
    end
    if (byte_ready !== 1'b0) begin
      errors++; $display("FAIL mrst_ready got %b exp 0", byte_ready);
    end
    fetch(32'h0);
    checks++;
    if (fetch_valid !== 1'b0) begin
      errors++; $display("FAIL mrst_idle_fetch got %b exp 0", fetch_valid);
    end
    do_start();
    for (int i = 0; i < 8; i++) push(v[i], i == 7);
    checks++;
    if (load_count !== 11'd8 || load_done !== 1'b1) begin
      errors++;
      $display("FAIL mrst_load got cnt=%0d done=%b exp cnt=8 done=1",
               load_count, load_done);
    end
    fetch(32'h0);
    checks++;
    if (fetch_instr !== 32'h0050_0093) begin
      errors++; $display("FAIL mrst_w0 got %h exp 00500093", fetch_instr);
    end
    fetch(32'h4);
    checks++;
    if (fetch_instr !== 32'h0010_0113) begin
      errors++; $display("FAIL mrst_w1 got %h exp 00100113", fetch_instr);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_last  = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 32'h0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_toggle();
    test_full();
    test_errors();
    test_back_to_back();
    test_start_fetch();
    test_rst_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
